// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the ALU (A) and load (B) writebacks,
// and runs a soft clear that zeroes every register through that same port.
module regfile_write_arbiter #(
    parameter int ADDR         = 4,
    parameter int SIZE         = 32,
    parameter bit ZERO_PROTECT = 1'b1
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Valid_A,
    input  logic [ADDR-1:0] Addr_A,
    input  logic [SIZE-1:0] Data_A,
    output logic            Ready_A,
    input  logic            Valid_B,
    input  logic [ADDR-1:0] Addr_B,
    input  logic [SIZE-1:0] Data_B,
    output logic            Ready_B,
    input  logic            Clr_Req,
    output logic            Busy,
    output logic            Clr_Done,
    output logic            Write_Reg,
    output logic [ADDR-1:0] W_Addr,
    output logic [SIZE-1:0] W_Data
);

    typedef enum logic {
        RUN,
        CLEAR
    } state_t;

    localparam logic [ADDR-1:0] LAST_ADDR = {ADDR{1'b1}};

    state_t          state_q, state_d;
    logic            prio_q, prio_d;
    logic [ADDR-1:0] cnt_q, cnt_d;
    logic            write_reg_q, write_reg_d;
    logic [ADDR-1:0] w_addr_q, w_addr_d;
    logic [SIZE-1:0] w_data_q, w_data_d;
    logic            clr_done_q, clr_done_d;
    logic            grant_a, grant_b;

    // prio_q = 0 favours A on a tie, 1 favours B; Rst_n gates the grants so Ready is 0 during reset
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (Rst_n && (state_q == RUN) && !Clr_Req) begin
            if (Valid_A && (!Valid_B || !prio_q)) begin
                grant_a = 1'b1;
            end else if (Valid_B) begin
                grant_b = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        write_reg_d = 1'b0;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        clr_done_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (Clr_Req) begin
                    // the request edge itself issues the first clear write to address 0
                    state_d     = CLEAR;
                    cnt_d       = '0;
                    write_reg_d = 1'b1;
                    w_addr_d    = '0;
                    w_data_d    = '0;
                end else if (grant_a) begin
                    prio_d = 1'b1;
                    if (!(ZERO_PROTECT && (Addr_A == '0))) begin
                        write_reg_d = 1'b1;
                        w_addr_d    = Addr_A;
                        w_data_d    = Data_A;
                    end
                end else if (grant_b) begin
                    prio_d = 1'b0;
                    if (!(ZERO_PROTECT && (Addr_B == '0))) begin
                        write_reg_d = 1'b1;
                        w_addr_d    = Addr_B;
                        w_data_d    = Data_B;
                    end
                end
            end
            CLEAR: begin
                // cnt_q is the address being written this cycle
                if (cnt_q == LAST_ADDR) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d       = cnt_q + ADDR'(1);
                    write_reg_d = 1'b1;
                    w_addr_d    = cnt_q + ADDR'(1);
                    w_data_d    = '0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= RUN;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
            write_reg_q <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            write_reg_q <= write_reg_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign Ready_A   = grant_a;
    assign Ready_B   = grant_b;
    assign Busy      = (state_q == CLEAR);
    assign Clr_Done  = clr_done_q;
    assign Write_Reg = write_reg_q;
    assign W_Addr    = w_addr_q;
    assign W_Data    = w_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: one zero-protected and one unprotected instance share
// stimulus and are compared each cycle against a queue-based behavioural model.
module tb_regfile_write_arbiter;

    localparam int ADDR = 4;
    localparam int SIZE = 32;
    localparam int NUMB = 1 << ADDR;

    logic            Clk = 1'b0;
    logic            Rst_n;
    logic            Valid_A, Valid_B, Clr_Req;
    logic [ADDR-1:0] Addr_A, Addr_B;
    logic [SIZE-1:0] Data_A, Data_B;

    logic            p_ready_a, p_ready_b, p_busy, p_clr_done, p_write_reg;
    logic [ADDR-1:0] p_w_addr;
    logic [SIZE-1:0] p_w_data;
    logic            u_ready_a, u_ready_b, u_busy, u_clr_done, u_write_reg;
    logic [ADDR-1:0] u_w_addr;
    logic [SIZE-1:0] u_w_data;

    int errors = 0;
    int checks = 0;

    // behavioural model: index 0 = protected instance, 1 = unprotected instance
    bit              m_prio;
    bit              m_clearing;
    bit              m_done;
    int              m_clr_q[$];
    bit              m_wr[2];
    logic [ADDR-1:0] m_waddr[2];
    logic [SIZE-1:0] m_wdata[2];
    bit              exp_ra, exp_rb;

    // random requester state, held until accepted
    bit              pa, pb;
    logic [ADDR-1:0] ra_addr, rb_addr;
    logic [SIZE-1:0] ra_data, rb_data;

    always #5 Clk = ~Clk;

    regfile_write_arbiter #(.ADDR(ADDR), .SIZE(SIZE), .ZERO_PROTECT(1'b1)) dut_p (
        .Clk(Clk), .Rst_n(Rst_n),
        .Valid_A(Valid_A), .Addr_A(Addr_A), .Data_A(Data_A), .Ready_A(p_ready_a),
        .Valid_B(Valid_B), .Addr_B(Addr_B), .Data_B(Data_B), .Ready_B(p_ready_b),
        .Clr_Req(Clr_Req), .Busy(p_busy), .Clr_Done(p_clr_done),
        .Write_Reg(p_write_reg), .W_Addr(p_w_addr), .W_Data(p_w_data)
    );

    regfile_write_arbiter #(.ADDR(ADDR), .SIZE(SIZE), .ZERO_PROTECT(1'b0)) dut_u (
        .Clk(Clk), .Rst_n(Rst_n),
        .Valid_A(Valid_A), .Addr_A(Addr_A), .Data_A(Data_A), .Ready_A(u_ready_a),
        .Valid_B(Valid_B), .Addr_B(Addr_B), .Data_B(Data_B), .Ready_B(u_ready_b),
        .Clr_Req(Clr_Req), .Busy(u_busy), .Clr_Done(u_clr_done),
        .Write_Reg(u_write_reg), .W_Addr(u_w_addr), .W_Data(u_w_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prio     = 1'b0;
        m_clearing = 1'b0;
        m_done     = 1'b0;
        m_clr_q.delete();
        for (int i = 0; i < 2; i++) begin
            m_wr[i]    = 1'b0;
            m_waddr[i] = '0;
            m_wdata[i] = '0;
        end
    endtask

    task automatic check_output();
        exp_ra = Rst_n && !m_clearing && !Clr_Req && Valid_A && (!Valid_B || m_prio == 1'b0);
        exp_rb = Rst_n && !m_clearing && !Clr_Req && Valid_B && (!Valid_A || m_prio == 1'b1);
        check("p.Ready_A", 32'(p_ready_a), 32'(exp_ra));
        check("p.Ready_B", 32'(p_ready_b), 32'(exp_rb));
        check("u.Ready_A", 32'(u_ready_a), 32'(exp_ra));
        check("u.Ready_B", 32'(u_ready_b), 32'(exp_rb));
        check("p.Busy", 32'(p_busy), 32'(m_clearing));
        check("u.Busy", 32'(u_busy), 32'(m_clearing));
        check("p.Clr_Done", 32'(p_clr_done), 32'(m_done));
        check("u.Clr_Done", 32'(u_clr_done), 32'(m_done));
        check("p.Write_Reg", 32'(p_write_reg), 32'(m_wr[0]));
        check("u.Write_Reg", 32'(u_write_reg), 32'(m_wr[1]));
        check("p.W_Addr", 32'(p_w_addr), 32'(m_waddr[0]));
        check("u.W_Addr", 32'(u_w_addr), 32'(m_waddr[1]));
        check("p.W_Data", p_w_data, m_wdata[0]);
        check("u.W_Data", u_w_data, m_wdata[1]);
    endtask

    task automatic model_write(input logic [ADDR-1:0] a, input logic [SIZE-1:0] d);
        for (int i = 0; i < 2; i++) begin
            if (i == 0 && a == '0) begin
                m_wr[i] = 1'b0;
            end else begin
                m_wr[i]    = 1'b1;
                m_waddr[i] = a;
                m_wdata[i] = d;
            end
        end
    endtask

    task automatic model_clear_write(input int a);
        for (int i = 0; i < 2; i++) begin
            m_wr[i]    = 1'b1;
            m_waddr[i] = ADDR'(a);
            m_wdata[i] = '0;
        end
    endtask

    task automatic model_edge();
        m_done  = 1'b0;
        m_wr[0] = 1'b0;
        m_wr[1] = 1'b0;
        if (m_clearing) begin
            if (m_clr_q.size() == 0) begin
                m_clearing = 1'b0;
                m_done     = 1'b1;
            end else begin
                model_clear_write(m_clr_q.pop_front());
            end
        end else if (Clr_Req) begin
            for (int a = 0; a < NUMB; a++) m_clr_q.push_back(a);
            m_clearing = 1'b1;
            model_clear_write(m_clr_q.pop_front());
        end else if (exp_ra) begin
            m_prio = 1'b1;
            model_write(Addr_A, Data_A);
        end else if (exp_rb) begin
            m_prio = 1'b0;
            model_write(Addr_B, Data_B);
        end
    endtask

    task automatic apply_stimulus(input logic va, input logic [ADDR-1:0] aa, input logic [SIZE-1:0] da,
                                  input logic vb, input logic [ADDR-1:0] ab, input logic [SIZE-1:0] db,
                                  input logic clr);
        Valid_A = va; Addr_A = aa; Data_A = da;
        Valid_B = vb; Addr_B = ab; Data_B = db;
        Clr_Req = clr;
        #1;
        check_output();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // asserts reset mid-cycle and checks the outputs fall before any clock edge
    task automatic async_reset();
        #2;
        Rst_n = 1'b0;
        model_reset();
        #1;
        check_output();
        @(posedge Clk);
        #1;
        check_output();
        Rst_n = 1'b1;
    endtask

    initial begin
        Rst_n = 1'b0;
        Valid_A = 1'b1; Addr_A = 4'd5; Data_A = 32'hAAAA;
        Valid_B = 1'b0; Addr_B = '0; Data_B = '0;
        Clr_Req = 1'b0;
        model_reset();
        #2;
        check_output();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        $display("[TB] single write from A");
        apply_stimulus(1'b1, 4'd3, 32'h1234, 1'b0, '0, '0, 1'b0);
        idle(2);

        $display("[TB] both requesters held");
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b1, 4'd1, 32'hA0 + i, 1'b1, 4'd2, 32'hB0 + i, 1'b0);
        idle(1);

        $display("[TB] soft clear while idle");
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        idle(NUMB + 2);

        $display("[TB] clear request with A pending");
        apply_stimulus(1'b1, 4'd9, 32'hCAFE, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < NUMB + 1; i++)
            apply_stimulus(1'b1, 4'd9, 32'hCAFE, 1'b0, '0, '0, 1'b0);
        idle(2);

        $display("[TB] write to address 0");
        apply_stimulus(1'b0, '0, '0, 1'b1, 4'd0, 32'hFFFF, 1'b0);
        idle(2);

        $display("[TB] reset in the middle of a clear");
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        idle(7);
        Valid_A = 1'b1; Addr_A = 4'd4; Data_A = 32'h44;
        async_reset();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        idle(NUMB + 2);

        $display("[TB] random traffic");
        pa = 1'b0;
        pb = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1'b1;
                ra_addr = ADDR'($urandom_range(0, NUMB - 1));
                ra_data = $urandom;
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1'b1;
                rb_addr = ADDR'($urandom_range(0, NUMB - 1));
                rb_data = $urandom;
            end
            if ($urandom_range(0, 299) == 0) begin
                Valid_A = pa; Addr_A = ra_addr; Data_A = ra_data;
                Valid_B = pb; Addr_B = rb_addr; Data_B = rb_data;
                Clr_Req = 1'b0;
                async_reset();
            end
            apply_stimulus(pa, ra_addr, ra_data, pb, rb_addr, rb_data,
                           1'($urandom_range(0, 39) == 0));
            if (exp_ra) pa = 1'b0;
            if (exp_rb) pb = 1'b0;
        end
        idle(NUMB + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
